writeback_stage: RTL and testbench
==================================

# writeback_stage

Writeback stage directly upstream of the 16x16 register file. It merges single-cycle ALU results and variable-latency load returns into the register file's single write port (`RegWrite`/`WriteReg`/`WriteData`), buffers loads that lose arbitration, and keeps a per-register pending-load scoreboard for the decode stage's stall logic.

## Interface
Parameters:
- `DATA_W`, 16, register/data width
- `REG_AW`, 4, register index width (16 registers)
- `LQ_DEPTH`, 4, load-return queue entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-low; asserted low clears all state immediately
- `alu_valid`  in  1  ALU result present this cycle
- `alu_rd`  in  REG_AW  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `ld_issue`  in  1  load issued to memory this cycle
- `ld_issue_rd`  in  REG_AW  destination of issued load
- `ld_valid`  in  1  load return data valid
- `ld_ready`  out  1  queue can accept a load return
- `ld_rd`  in  REG_AW  load return destination
- `ld_data`  in  DATA_W  load return data
- `RegWrite`  out  1  register-file write enable (registered)
- `WriteReg`  out  REG_AW  register-file write index (registered)
- `WriteData`  out  DATA_W  register-file write data (registered)
- `pending`  out  2**REG_AW  bit i set = load to register i outstanding
- `lq_empty`  out  1  load queue empty

## Operation
- Load return accepted when `ld_valid && ld_ready`; entry {`ld_rd`,`ld_data`} pushed to queue tail.
- `ld_ready` = !full, from registered count only; no pass-through when full, even if the head drains in the same cycle.
- Arbitration per cycle, ALU strict priority:
  - `alu_valid`=1: next output = {1,`alu_rd`,`alu_data`}; queue head stays.
  - else queue non-empty: next output = {1, head rd, head data}; head popped.
  - else: next `RegWrite`=0; `WriteReg`/`WriteData` hold last value.
- ALU results never buffered; no backpressure on ALU path.
- Scoreboard:
  - `ld_issue` sets `pending[ld_issue_rd]`.
  - Load writeback (pop) clears `pending[head rd]` on the same edge that loads the output register.
  - Set and clear of the same bit on one edge: set wins.
  - ALU writes never change `pending`.
  - `ld_issue` to an already-pending register is illegal (decode guarantees); bench asserts it never occurs.
- Push and pop in the same cycle allowed when not full; count unchanged.
- Register 0 not special; written like any other.
- Data widths pass through unmodified; no arithmetic except pointer/count wrap modulo LQ_DEPTH.

## Timing
- Reset (low, async): queue empty, pointers/count 0, `pending`=0, `RegWrite`=0, `WriteReg`=0, `WriteData`=0, `ld_ready`=1, `lq_empty`=1. Reset mid-operation discards queued loads and outstanding pending bits.
- ALU latency: `alu_valid` sampled at edge N → `RegWrite`=1 during cycle N..N+1; RF captures it at edge N+1.
- Load latency, no ALU contention: accepted at edge N → popped at edge N+1 → `RegWrite`=1 until edge N+2.
- Each consecutive ALU cycle delays queued loads by one cycle; queue drains at one entry per idle cycle.
- `pending`, `ld_ready`, `lq_empty` are registered-state outputs, valid one cycle after the causing edge.
- Full: `ld_ready`=0 the cycle after the LQ_DEPTH-th push; returns to 1 the cycle after a pop.

## Structure
- Package `wb_pkg`: `DATA_W`, `REG_AW`, `NUM_REGS`, `LQ_DEPTH` defaults; typedef `wb_req_t` {rd, data}.
- Sub-module `wb_load_fifo`: synchronous FIFO of `wb_req_t`, async active-low reset, push/pop/full/empty/count.
- Top: arbiter, output register, scoreboard.

## Test plan
- Reset: drive `reset` low mid-stream with 3 loads queued and `pending`=16'h000E → all outputs zero immediately, `ld_ready`=1, `lq_empty`=1.
- ALU only: `alu_valid` with rd=3, data=16'h1234 → next cycle `RegWrite`=1, `WriteReg`=3, `WriteData`=16'h1234; next idle cycle `RegWrite`=0.
- Load path: `ld_issue` rd=5 → `pending`=16'h0020; return rd=5, data=16'hBEEF → `RegWrite` two cycles later with 16'hBEEF; `pending`=0 the same cycle.
- Contention: ALU valid 3 cycles (rd 1,2,3) while a load returns rd=7 in cycle 1 → writes ordered 1,2,3,7; load written in cycle 5.
- Full: ALU held valid, push 4 loads → `ld_ready`=0; 5th return held; ALU drops → loads drain FIFO-ordered, `ld_ready` reasserts after first pop.
- Set/clear collision: load to rd=4 popped on the same edge as `ld_issue` rd=4 → `pending[4]` remains 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the load-return record used by the writeback stage.
package wb_pkg;
  localparam int DATA_W   = 16;
  localparam int REG_AW   = 4;
  localparam int NUM_REGS = 1 << REG_AW;
  localparam int LQ_DEPTH = 4;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_load_fifo.sv
// Load-return queue: holds loads that lost the write port to the ALU.
module wb_load_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = LQ_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_req_t          push_req,
  input  logic             pop,
  output wb_req_t          head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap on their own because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_req;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges ALU results and queued load returns into the single
// register-file write port and tracks which registers still await a load.
module writeback_stage #(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int REG_AW   = wb_pkg::REG_AW,
  parameter int LQ_DEPTH = wb_pkg::LQ_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [REG_AW-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     ld_issue,
  input  logic [REG_AW-1:0]        ld_issue_rd,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REG_AW-1:0]        ld_rd,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     RegWrite,
  output logic [REG_AW-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  output logic [(1<<REG_AW)-1:0]   pending,
  output logic                     lq_empty
);
  import wb_pkg::*;

  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;

  // Load return handshake: a return transfers on a rising edge where
  // ld_valid && ld_ready; ld_ready depends only on registered queue occupancy.
  wb_req_t              lq_in;
  wb_req_t              lq_head;
  logic                 lq_full;
  logic                 lq_is_empty;
  logic                 lq_push;
  logic                 lq_pop;
  logic [CNT_W-1:0]     lq_count;
  logic [(1<<REG_AW)-1:0] pending_nxt;

  assign lq_in    = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !lq_full;
  assign lq_empty = lq_is_empty;
  assign lq_push  = ld_valid && ld_ready;
  // ALU has strict priority; the queue only drains on cycles without an ALU result.
  assign lq_pop   = !alu_valid && !lq_is_empty;

  wb_load_fifo #(
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk      (clk),
    .rst_n    (reset),
    .push     (lq_push),
    .push_req (lq_in),
    .pop      (lq_pop),
    .head     (lq_head),
    .full     (lq_full),
    .empty    (lq_is_empty),
    .count    (lq_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (alu_valid) begin
      RegWrite  <= 1'b1;
      WriteReg  <= alu_rd;
      WriteData <= alu_data;
    end else if (lq_pop) begin
      RegWrite  <= 1'b1;
      WriteReg  <= lq_head.rd;
      WriteData <= lq_head.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  // A new issue to the register being written back this edge keeps the bit set.
  always_comb begin
    pending_nxt = pending;
    if (lq_pop)   pending_nxt[lq_head.rd]  = 1'b0;
    if (ld_issue) pending_nxt[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) assert (lq_count <= CNT_W'(LQ_DEPTH));
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the writeback rules.
module tb_writeback_stage;
  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int LQ_DEPTH = 4;
  localparam int W = REG_AW + DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              alu_valid = 1'b0;
  logic [REG_AW-1:0] alu_rd = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              ld_issue = 1'b0;
  logic [REG_AW-1:0] ld_issue_rd = '0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [REG_AW-1:0] ld_rd = '0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              RegWrite;
  logic [REG_AW-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [15:0]       pending;
  logic              lq_empty;

  int checks = 0;
  int failures = 0;

  writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .pending(pending), .lq_empty(lq_empty)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [W-1:0]      exp_q[$];
  logic              m_rw = 1'b0;
  logic [REG_AW-1:0] m_wreg = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [15:0]       m_pend = '0;
  logic              m_accept = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_rw = 1'b0; m_wreg = '0; m_wdata = '0; m_pend = '0; m_accept = 1'b0;
  endtask

  task automatic model_step();
    logic [W-1:0] e;
    logic [15:0]  pend_before;
    logic         popped;
    logic [3:0]   prd;
    pend_before = m_pend;
    popped = 1'b0;
    prd = '0;
    m_accept = ld_valid && (exp_q.size() < LQ_DEPTH);
    if (alu_valid) begin
      m_rw = 1'b1; m_wreg = alu_rd; m_wdata = alu_data;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      m_rw = 1'b1; m_wreg = e[W-1:DATA_W]; m_wdata = e[DATA_W-1:0];
      prd = e[W-1:DATA_W];
      popped = 1'b1;
      m_pend[prd] = 1'b0;
    end else begin
      m_rw = 1'b0;
    end
    if (ld_issue) begin
      if (pend_before[ld_issue_rd] && !(popped && prd == ld_issue_rd)) begin
        failures++;
        $display("FAIL illegal_issue rd=%0d already pending at %0t", ld_issue_rd, $time);
      end
      m_pend[ld_issue_rd] = 1'b1;
    end
    if (m_accept) exp_q.push_back({ld_rd, ld_data});
  endtask

  always @(negedge reset) model_reset();
  always @(posedge clk) if (reset) model_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("RegWrite", 32'(RegWrite), 32'(m_rw));
    chk("WriteReg", 32'(WriteReg), 32'(m_wreg));
    chk("WriteData", 32'(WriteData), 32'(m_wdata));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("ld_ready", 32'(ld_ready), 32'(exp_q.size() < LQ_DEPTH));
    chk("lq_empty", 32'(lq_empty), 32'(exp_q.size() == 0));
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] r);
    ld_issue = 1'b1; ld_issue_rd = r;
    step();
    ld_issue = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic rw, input logic [3:0] r, input logic [15:0] d);
    chk({name, "_rw"}, 32'(RegWrite), 32'(rw));
    chk({name, "_reg"}, 32'(WriteReg), 32'(r));
    chk({name, "_data"}, 32'(WriteData), 32'(d));
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] out_rds[$];
  int pcts[4] = '{10, 50, 95, 30};
  int alu_pct;
  int idx;
  logic [3:0] r;

  initial begin
    repeat (2) step();
    chk_out("reset_init", 1'b0, 4'd0, 16'h0);
    chk("reset_init_ready", 32'(ld_ready), 32'd1);
    chk("reset_init_empty", 32'(lq_empty), 32'd1);
    @(negedge clk) reset = 1'b1;
    step();

    // ALU only
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
    step();
    alu_valid = 1'b0;
    chk_out("alu_write", 1'b1, 4'd3, 16'h1234);
    step();
    chk_out("alu_idle", 1'b0, 4'd3, 16'h1234);

    // Load path
    issue(4'd5);
    chk("load_pending_set", 32'(pending), 32'h0020);
    ld_valid = 1'b1; ld_rd = 4'd5; ld_data = 16'hBEEF;
    step();
    ld_valid = 1'b0;
    chk("load_accepted_rw", 32'(RegWrite), 32'd0);
    chk("load_queued", 32'(lq_empty), 32'd0);
    step();
    chk_out("load_write", 1'b1, 4'd5, 16'hBEEF);
    chk("load_pending_clr", 32'(pending), 32'h0000);

    // Contention: ALU rd 1,2,3 while load rd 7 returns
    issue(4'd7);
    alu_valid = 1'b1; alu_rd = 4'd1; alu_data = 16'h0101;
    ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 16'h7777;
    step();
    ld_valid = 1'b0;
    chk_out("cont_1", 1'b1, 4'd1, 16'h0101);
    alu_rd = 4'd2; alu_data = 16'h0202;
    step();
    chk_out("cont_2", 1'b1, 4'd2, 16'h0202);
    alu_rd = 4'd3; alu_data = 16'h0303;
    step();
    chk_out("cont_3", 1'b1, 4'd3, 16'h0303);
    alu_valid = 1'b0;
    step();
    chk_out("cont_7", 1'b1, 4'd7, 16'h7777);
    chk("cont_pending", 32'(pending), 32'h0000);

    // Full queue with ALU holding the port
    for (int i = 0; i < 5; i++) issue(4'(9 + i));
    alu_valid = 1'b1; alu_rd = 4'd8; alu_data = 16'h8888;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = 4'(9 + i); ld_data = 16'hA000 + 16'(i);
      step();
    end
    chk("full_ready_low", 32'(ld_ready), 32'd0);
    ld_rd = 4'd13; ld_data = 16'hA004;
    step();
    chk("full_held", 32'(ld_ready), 32'd0);
    alu_valid = 1'b0;
    step();
    chk_out("drain_9", 1'b1, 4'd9, 16'hA000);
    chk("drain_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk_out("drain", 1'b1, 4'(9 + i), 16'hA000 + 16'(i));
      step();
    end
    chk("drain_done_rw", 32'(RegWrite), 32'd0);
    chk("drain_done_pend", 32'(pending), 32'h0000);

    // Set/clear collision on register 4
    issue(4'd4);
    ld_valid = 1'b1; ld_rd = 4'd4; ld_data = 16'h4444;
    step();
    ld_valid = 1'b0;
    issue(4'd4);
    chk("collide_pending", 32'(pending), 32'h0010);
    chk_out("collide_write", 1'b1, 4'd4, 16'h4444);
    ld_valid = 1'b1; ld_data = 16'h4545;
    step();
    ld_valid = 1'b0;
    step();
    chk("collide_clear", 32'(pending), 32'h0000);

    // Mid-stream reset with three loads queued
    for (int i = 1; i < 4; i++) issue(4'(i));
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'h0F0F;
    for (int i = 1; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = 4'(i); ld_data = 16'hC000 + 16'(i);
      step();
    end
    ld_valid = 1'b0;
    chk("pre_reset_pending", 32'(pending), 32'h000E);
    chk("pre_reset_queued", 32'(lq_empty), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 4'd0, 16'h0);
    chk("mid_reset_pend", 32'(pending), 32'h0000);
    chk("mid_reset_ready", 32'(ld_ready), 32'd1);
    chk("mid_reset_empty", 32'(lq_empty), 32'd1);
    alu_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      alu_pct = pcts[(c / 250) % 4];
      if (ld_valid && m_accept) ld_valid = 1'b0;
      if (ld_issue) out_rds.push_back(ld_issue_rd);
      ld_issue = 1'b0;
      alu_valid = ($urandom_range(0, 99) < alu_pct);
      alu_rd = 4'($urandom);
      alu_data = 16'($urandom);
      r = 4'($urandom_range(0, 15));
      if (!m_pend[r] && $urandom_range(0, 99) < 35) begin
        ld_issue = 1'b1; ld_issue_rd = r;
      end
      if (!ld_valid && out_rds.size() > 0 && $urandom_range(0, 99) < 50) begin
        idx = $urandom_range(0, out_rds.size() - 1);
        ld_rd = out_rds[idx];
        out_rds.delete(idx);
        ld_data = 16'($urandom);
        ld_valid = 1'b1;
      end
      step();
    end

    alu_valid = 1'b0;
    ld_issue = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (ld_valid && m_accept) ld_valid = 1'b0;
      step();
    end
    chk("final_empty", 32'(lq_empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
